// File: rtl/relu_requant_2.sv
// relu_requant_2: ReLU activation plus requantization of one dense_layer_2
// output vector. A run snapshots the input vector in LOAD, then converts one
// element per cycle in PROC (negative -> 0, else shift right by SHIFT and
// clamp to the signed OUT_W maximum), and pulses done for one cycle in DONE.
// Optional build macro: RELU_REQUANT_ROUND_EN adds 2^(SHIFT-1) before the
// shift (round half up); without it the shift truncates.
module relu_requant_2 #(
  parameter int VEC_SIZE = 64,
  parameter int IN_W     = 40,
  parameter int OUT_W    = 24,
  parameter int SHIFT    = 12
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [VEC_SIZE-1:0][IN_W-1:0]      in_vector,
  output logic                               busy,
  output logic                               done,
  output logic [VEC_SIZE-1:0][OUT_W-1:0]     out_vector,
  output logic [$clog2(VEC_SIZE):0]          sat_count
);

  localparam int IDX_W = $clog2(VEC_SIZE);
  localparam int SAT_W = IDX_W + 1;

  // Largest positive OUT_W value, widened to the IN_W+1-bit working path.
  localparam logic signed [IN_W:0] SAT_MAX =
    {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};

`ifdef RELU_REQUANT_ROUND_EN
  localparam logic signed [IN_W:0] RND_ADD =
    {{(IN_W+1-SHIFT){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_PROC,
    S_DONE
  } state_e;

  state_e                           state_q, state_d;
  logic [IDX_W-1:0]                 idx_q;
  logic [SAT_W-1:0]                 sat_q;
  logic [VEC_SIZE-1:0][IN_W-1:0]    snap_q;
  logic [VEC_SIZE-1:0][OUT_W-1:0]   out_q;

  logic signed [IN_W:0]             elem_ext;
  logic signed [IN_W:0]             elem_rnd;
  logic signed [IN_W:0]             elem_shf;
  logic                             elem_neg;
  logic                             elem_clamp;
  logic [OUT_W-1:0]                 elem_d;
  logic                             last_elem;

  assign last_elem = (idx_q == IDX_W'(VEC_SIZE - 1));

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its inputs, independent of block order.
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_LOAD;
      S_LOAD: state_d = S_PROC;
      S_PROC: if (last_elem) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs decoded from the current state.
  always_comb begin
    busy = (state_q == S_LOAD) || (state_q == S_PROC);
    done = (state_q == S_DONE);
  end

  // Per-element ReLU, optional rounding, arithmetic shift and clamp.
  always_comb begin
    elem_ext   = $signed({snap_q[idx_q][IN_W-1], snap_q[idx_q]});
    elem_neg   = elem_ext[IN_W];
`ifdef RELU_REQUANT_ROUND_EN
    elem_rnd   = elem_ext + RND_ADD;
`else
    elem_rnd   = elem_ext;
`endif
    elem_shf   = elem_rnd >>> SHIFT;
    elem_clamp = !elem_neg && (elem_shf > SAT_MAX);
    if (elem_neg) begin
      elem_d = '0;
    end else if (elem_clamp) begin
      elem_d = SAT_MAX[OUT_W-1:0];
    end else begin
      elem_d = elem_shf[OUT_W-1:0];
    end
  end

  // Snapshot, element index, result vector and clamp counter.
  always_ff @(posedge clk) begin
    // NOTE: the snapshot and result arrays are cleared on reset as well, so
    // a reset leaves no stale data visible on out_vector.
    if (!rst) begin
      idx_q  <= '0;
      sat_q  <= '0;
      snap_q <= '0;
      out_q  <= '0;
    end else begin
      unique case (state_q)
        S_LOAD: begin
          snap_q <= in_vector;
          idx_q  <= '0;
          sat_q  <= '0;
        end
        S_PROC: begin
          out_q[idx_q] <= elem_d;
          idx_q        <= idx_q + IDX_W'(1);
          if (elem_clamp) sat_q <= sat_q + SAT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign out_vector = out_q;
  assign sat_count  = sat_q;

endmodule

// File: tb/tb_relu_requant_2.sv
// Directed testbench for relu_requant_2 with hand-computed expectations.
// Build with RELU_REQUANT_ROUND_EN defined to check the rounding variant.
module tb_relu_requant_2;

  localparam int VEC   = 64;
  localparam int IN_W  = 40;
  localparam int OUT_W = 24;
  localparam int SAT_W = 7;

  logic                         clk;
  logic                         rst;
  logic                         start;
  logic [VEC-1:0][IN_W-1:0]     in_vector;
  logic                         busy;
  logic                         done;
  logic [VEC-1:0][OUT_W-1:0]    out_vector;
  logic [SAT_W-1:0]             sat_count;

  int n_tests = 0;
  int n_fail  = 0;

  relu_requant_2 dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_vector  (in_vector),
    .busy       (busy),
    .done       (done),
    .out_vector (out_vector),
    .sat_count  (sat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs for elements 0..10 of the directed vector.
`ifdef RELU_REQUANT_ROUND_EN
  int exp_dir [11] = '{2, 0, 1, 8388607, 8388607, 1, 24, 8388607, 0, 10, 1};
`else
  int exp_dir [11] = '{1, 0, 1, 8388607, 8388607, 0, 24, 8388607, 0, 10, 1};
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fill_const(input logic [IN_W-1:0] v);
    for (int i = 0; i < VEC; i++) in_vector[i] = v;
  endtask

  task automatic fill_directed();
    fill_const(-40'sd5);
    in_vector[0]  = 40'd6144;
    in_vector[1]  = -40'sd1;
    in_vector[2]  = 40'd4096;
    in_vector[3]  = 40'h7F_FFFF_FFFF;
    in_vector[4]  = 40'h07_FFFF_F000;
    in_vector[5]  = 40'd4095;
    in_vector[6]  = 40'd100000;
    in_vector[7]  = 40'h08_0000_0000;
    in_vector[8]  = 40'h80_0000_0000;
    in_vector[9]  = 40'd40960;
    in_vector[10] = 40'd6143;
  endtask

  task automatic check_directed(input string tag);
    for (int i = 0; i < 11; i++)
      check($sformatf("%s_out%0d", tag, i), 64'(out_vector[i]), 64'(exp_dir[i]));
    check({tag, "_out20"}, 64'(out_vector[20]), 64'd0);
    check({tag, "_out63"}, 64'(out_vector[63]), 64'd0);
    check({tag, "_sat"}, 64'(sat_count), 64'd2);
  endtask

  // Pulse start for one cycle and watch 150 cycles; optionally disturb the
  // inputs and re-pulse start mid-PROC. Cycle n is counted from the IDLE
  // cycle in which start is sampled high.
  task automatic run_capture(input bit disturb, output int lat, output int pulses);
    lat    = 0;
    pulses = 0;
    start  = 1'b1;
    for (int n = 1; n <= 150; n++) begin
      @(negedge clk);
      if (n == 1) begin
        start = 1'b0;
        check("busy_in_load", 64'(busy), 64'd1);
      end
      if (disturb && n == 10) begin
        fill_const(40'h00_0010_0000);
        start = 1'b1;
      end
      if (disturb && n == 11) start = 1'b0;
      if (n == 65) check("busy_last_proc", 64'(busy), 64'd1);
      if (n == 66) check("busy_in_done", 64'(busy), 64'd0);
      if (done) begin
        pulses++;
        if (lat == 0) lat = n;
      end
    end
  endtask

  initial begin
    int lat, pulses, d1, d2;
    bit busy_log [0:200];

    rst   = 1'b0;
    start = 1'b0;
    fill_const('0);
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_sat", 64'(sat_count), 64'd0);
    check("rst_out_zero", 64'(|out_vector), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // Directed vector: ReLU, truncation/rounding and saturation corners.
    fill_directed();
    run_capture(1'b0, lat, pulses);
    check("dir_latency", 64'(lat), 64'd66);
    check("dir_pulses", 64'(pulses), 64'd1);
    check_directed("dir");

    // All negative inputs overwrite every element with zero.
    fill_const(-40'sd5);
    run_capture(1'b0, lat, pulses);
    check("neg_latency", 64'(lat), 64'd66);
    check("neg_sat", 64'(sat_count), 64'd0);
    for (int i = 0; i < VEC; i++)
      check($sformatf("neg_out%0d", i), 64'(out_vector[i]), 64'd0);

    // Inputs changed and start re-pulsed during PROC have no effect.
    fill_directed();
    run_capture(1'b1, lat, pulses);
    check("dist_latency", 64'(lat), 64'd66);
    check("dist_pulses", 64'(pulses), 64'd1);
    check_directed("dist");

    // Reset while processing index 30 aborts the run.
    fill_directed();
    start = 1'b1;
    for (int n = 1; n <= 32; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
    end
    check("mid_busy_before_rst", 64'(busy), 64'd1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("midrst_out_zero", 64'(|out_vector), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_sat", 64'(sat_count), 64'd0);
    pulses = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("midrst_no_done", 64'(pulses), 64'd0);
    run_capture(1'b0, lat, pulses);
    check("recover_latency", 64'(lat), 64'd66);
    check_directed("recover");

    // Start held high: back-to-back runs 67 cycles apart.
    fill_const(-40'sd5);
    d1     = 0;
    d2     = 0;
    pulses = 0;
    start  = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      busy_log[n] = busy;
      if (done) begin
        pulses++;
        if (pulses == 1) d1 = n;
        if (pulses == 2) begin
          d2    = n;
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    check("b2b_first_done", 64'(d1), 64'd66);
    check("b2b_spacing", 64'(d2 - d1), 64'd67);
    check("b2b_pulses", 64'(pulses), 64'd2);
    if (d1 > 1 && d1 < 190) begin
      check("b2b_busy_proc", 64'(busy_log[d1-1]), 64'd1);
      check("b2b_busy_done", 64'(busy_log[d1]), 64'd0);
      check("b2b_busy_idle", 64'(busy_log[d1+1]), 64'd0);
      check("b2b_busy_load", 64'(busy_log[d1+2]), 64'd1);
    end
    check("b2b_sat", 64'(sat_count), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/relu_requant_2.md
RELU_REQUANT_2 -- requirements
Module: relu_requant_2

Interface
REQ-001 SHALL have parameter VEC_SIZE, default 64: number of elements per vector (equals dense_layer_2 output count).
REQ-002 SHALL have parameter IN_W, default 40: signed accumulator width of each input element.
REQ-003 SHALL have parameter OUT_W, default 24: signed width of each output element (equals next dense layer input width).
REQ-004 SHALL have parameter SHIFT, default 12: requantization right-shift amount.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have port start, input, 1 bit: run request, sampled only in IDLE.
REQ-008 SHALL have port in_vector, input, VEC_SIZE x IN_W signed: dense_layer_2 output_vector.
REQ-009 SHALL have port busy, output, 1 bit: high from LOAD through PROC.
REQ-010 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port out_vector, output, VEC_SIZE x OUT_W signed: registered activated and requantized vector.
REQ-012 SHALL have port sat_count, output, $clog2(VEC_SIZE)+1 bits: number of elements clamped in the last run.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, PROC, DONE; transitions: IDLE->LOAD on start=1, LOAD->PROC unconditionally, PROC->DONE after index VEC_SIZE-1 is written, DONE->IDLE unconditionally.
REQ-014 SHALL, in LOAD, snapshot all of in_vector into an internal register, clear the element index to 0 and clear sat_count.
REQ-015 SHALL, in PROC, process exactly one element per cycle from the snapshot in ascending index order, writing out_vector[idx] and incrementing idx.
REQ-016 SHALL apply ReLU per element: a negative input yields 0.
REQ-017 SHALL arithmetically shift non-negative inputs right by SHIFT, computing in IN_W+1 bits.
REQ-018 SHALL clamp any shifted result above 2^(OUT_W-1)-1 to 2^(OUT_W-1)-1 (8388607) and increment sat_count once per clamped element.
REQ-019 SHALL assert done for exactly one cycle in DONE; the first done-high cycle is VEC_SIZE+2 cycles after the cycle in which start was sampled high (66 at default).
REQ-020 SHALL hold busy high in LOAD and PROC and low in IDLE and DONE.
REQ-021 SHALL ignore start in any state other than IDLE; start held high through DONE SHALL begin a new run on the next IDLE cycle.
REQ-022 SHALL leave out_vector elements not yet written in the current run at their previous values; final values hold until overwritten.
REQ-023 SHALL make in_vector changes after LOAD have no effect on the current run.
REQ-024 SHALL hold sat_count stable from DONE until the next LOAD.

Reset
REQ-025 SHALL, when rst=0 at a clock edge, force state to IDLE, idx to 0, busy and done to 0, sat_count to 0, every out_vector element to 0 and the snapshot register to 0.
REQ-026 SHALL, on reset mid-run, abort the run with no done pulse; the first start after rst returns to 1 SHALL run normally.

Configuration
REQ-027 SHALL support macro RELU_REQUANT_ROUND_EN: when defined, add 2^(SHIFT-1) to each non-negative element in the IN_W+1-bit path before the shift (round half up), with the saturation check applied after rounding; when undefined, truncate (plain shift).

Verification
REQ-028 SHALL cover: all inputs = -5 -> all outputs 0, sat_count 0, done in cycle 66 after start.
REQ-029 SHALL cover: input[0] = 6144 (0x1800) -> out[0] = 1 without the macro, out[0] = 2 with RELU_REQUANT_ROUND_EN.
REQ-030 SHALL cover: input[3] = 2^39-1, input[7] = 2^35 -> both outputs 8388607, sat_count 2; input[5] = 4095 -> out[5] = 0 truncated, 1 rounded.
REQ-031 SHALL cover: in_vector changed and start pulsed during PROC -> outputs match the original snapshot, no second run, single done pulse.
REQ-032 SHALL cover: rst=0 at PROC index 30 -> next cycle all outputs 0, busy 0, no done; a subsequent start completes with correct results.
REQ-033 SHALL cover: start held high continuously -> back-to-back runs, done pulses 67 cycles apart, busy low only during the DONE and IDLE cycle between runs.
